// File: rtl/arbiter_pkg.sv
// rtl/arbiter_pkg.sv - shared channel-index helpers for the arbiters and their return path
package arbiter_pkg;

  localparam int DEFAULT_SIZE = 4;

  function automatic int idx_width(input int size);
    return (size <= 2) ? 1 : $clog2(size);
  endfunction

  typedef logic [idx_width(DEFAULT_SIZE)-1:0] chan_idx_t;

endpackage

// File: rtl/onehot_to_binary.sv
// rtl/onehot_to_binary.sv - combinational priority encoder, lowest set bit wins
module onehot_to_binary
  import arbiter_pkg::*;
#(
  parameter int SIZE  = 4,
  parameter int IDX_W = idx_width(SIZE)
) (
  input  logic [SIZE-1:0]  i_onehot,
  output logic [IDX_W-1:0] o_index
);

  // Scan downward so the lowest set bit is the last write.
  always_comb begin
    o_index = '0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (i_onehot[i]) o_index = IDX_W'(i);
    end
  end

endmodule

// File: rtl/grant_order_response_router.sv
// rtl/grant_order_response_router.sv - steers shared-port responses back to channels in grant order
// Optional protocol checks: GRANT_ORDER_RESPONSE_ROUTER_CHECKS_EN
module grant_order_response_router
  import arbiter_pkg::*;
#(
  parameter int SIZE  = 4,
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             grant_valid,
  input  logic [SIZE-1:0]  grant,
  output logic             tracker_full,
  output logic             tracker_empty,
  input  logic             downstream_response_valid,
  input  logic [WIDTH-1:0] downstream_response_data,
  output logic             downstream_response_ready,
  output logic [SIZE-1:0]  channel_response_valid,
  output logic [WIDTH-1:0] channel_response_data,
  input  logic [SIZE-1:0]  channel_response_ready,
  output logic             error
);

  localparam int IDX_W = idx_width(SIZE);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [IDX_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic [IDX_W-1:0] w_grant_idx;
  logic [IDX_W-1:0] w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  onehot_to_binary #(
    .SIZE  (SIZE),
    .IDX_W (IDX_W)
  ) u_grant_enc (
    .i_onehot (grant),
    .o_index  (w_grant_idx)
  );

  // Flags come from registered occupancy only, so a same-cycle pop never frees a slot for a push.
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_head  = r_mem[r_rd_ptr];
  assign w_push  = grant_valid & ~w_full;
  assign w_pop   = downstream_response_valid & downstream_response_ready;

  assign tracker_full              = w_full;
  assign tracker_empty             = w_empty;
  assign downstream_response_ready = ~w_empty & channel_response_ready[w_head];
  assign channel_response_data     = downstream_response_data;

  always_comb begin
    channel_response_valid = '0;
    if (downstream_response_valid && !w_empty) begin
      channel_response_valid = {{(SIZE-1){1'b0}}, 1'b1} << w_head;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= w_grant_idx;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef GRANT_ORDER_RESPONSE_ROUTER_CHECKS_EN
  logic r_error;
  logic r_resp_while_empty;
  logic w_grant_onehot;

  assign w_grant_onehot = (grant != '0) && ((grant & (grant - SIZE'(1))) == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_error            <= 1'b0;
      r_resp_while_empty <= 1'b0;
    end else begin
      r_resp_while_empty <= downstream_response_valid & w_empty;
      if ((grant_valid && !w_grant_onehot) ||
          (grant_valid && w_full) ||
          (downstream_response_valid && w_empty && r_resp_while_empty)) begin
        r_error <= 1'b1;
      end
    end
  end

  assign error = r_error;
`else
  assign error = 1'b0;
`endif

endmodule
